// File: rtl/sklansky_sub_pipe.sv
// Pipelined add/subtract unit on a Sklansky parallel-prefix carry tree.
// One register per prefix level, plus operand-prep and result stages.
module sklansky_sub_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned L   = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Operand preparation; the carry-in is folded into bit 0's generate.
  logic [WIDTH-1:0] b_x, p_in, g_in;
  always_comb begin
    b_x     = in_b ^ {WIDTH{in_op}};
    p_in    = in_a ^ b_x;
    g_in    = in_a & b_x;
    g_in[0] = g_in[0] | (p_in[0] & in_op);
  end

  // Stage k holds the prefix state after k levels; stage 0 is the prepared operands.
  logic             valid_q [0:L];
  logic             op_q    [0:L];
  logic             amsb_q  [0:L];
  logic             bmsb_q  [0:L];
  logic [WIDTH-1:0] g_q     [0:L];
  logic [WIDTH-1:0] p_q     [0:L];
  logic [WIDTH-1:0] p0_q    [1:L];
  logic [WIDTH-1:0] g_lvl   [1:L];
  logic [WIDTH-1:0] p_lvl   [1:L];

  always_comb begin
    for (int k = 1; k <= int'(L); k++) begin
      g_lvl[k] = g_q[k-1];
      p_lvl[k] = p_q[k-1];
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (((i >> (k - 1)) & 1) == 1) begin
          int j;
          j = (i | ((1 << (k - 1)) - 1)) - (1 << (k - 1));
          g_lvl[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][j]);
          // Groups reaching bit 0 are complete after this level: grey cell, p left alone.
          if (i >= (1 << k)) begin
            p_lvl[k][i] = p_q[k-1][i] & p_q[k-1][j];
          end
        end
      end
    end
  end

  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  always_comb begin
    res_c = p0_q[L] ^ {g_q[L][WIDTH-2:0], op_q[L]};
    ovf_c = (amsb_q[L] == bmsb_q[L]) && (res_c[MSB] != amsb_q[L]);
  end

  // Group propagate is not needed once the tree is complete.
  logic unused_p_top;
  assign unused_p_top = ^p_q[L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= int'(L); k++) begin
        valid_q[k] <= 1'b0;
        op_q[k]    <= 1'b0;
        amsb_q[k]  <= 1'b0;
        bmsb_q[k]  <= 1'b0;
        g_q[k]     <= '0;
        p_q[k]     <= '0;
      end
      for (int k = 1; k <= int'(L); k++) begin
        p0_q[k] <= '0;
      end
      out_valid <= 1'b0;
      out_res   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      op_q[0]    <= in_op;
      amsb_q[0]  <= in_a[MSB];
      bmsb_q[0]  <= b_x[MSB];
      g_q[0]     <= g_in;
      p_q[0]     <= p_in;
      p0_q[1]    <= p_q[0];
      for (int k = 1; k <= int'(L); k++) begin
        valid_q[k] <= valid_q[k-1];
        op_q[k]    <= op_q[k-1];
        amsb_q[k]  <= amsb_q[k-1];
        bmsb_q[k]  <= bmsb_q[k-1];
        g_q[k]     <= g_lvl[k];
        p_q[k]     <= p_lvl[k];
      end
      for (int k = 2; k <= int'(L); k++) begin
        p0_q[k] <= p0_q[k-1];
      end
      out_valid <= valid_q[L];
      out_res   <= res_c;
      out_carry <= g_q[L][MSB];
      out_ovf   <= ovf_c;
      out_zero  <= ~|res_c;
    end
  end

endmodule

// File: tb/tb_sklansky_sub_pipe.sv
// Self-checking bench for sklansky_sub_pipe (WIDTH=8): vector table, handshake
// corner cases and a randomised scoreboard run against an arithmetic model.
module tb_sklansky_sub_pipe;

  localparam int LAT = 5;
  localparam int NV  = 10;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_op, out_valid, out_ready;
  logic       out_carry, out_ovf, out_zero;
  logic [7:0] in_a, in_b, out_res;

  always #5 clk = ~clk;

  sklansky_sub_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_carry(out_carry),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       carry;
    logic       ovf;
    logic       zero;
  } res_t;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       carry;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t tbl [NV];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  res_t exp_q   [$];
  int   pop_cyc [$];

  always @(posedge clk) cyc++;

  function automatic res_t model(input logic op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] bm;
    logic [8:0] s;
    res_t       r;
    bm      = op ? ~b : b;
    s       = {1'b0, a} + {1'b0, bm} + {8'd0, op};
    r.res   = s[7:0];
    r.carry = s[8];
    r.ovf   = (a[7] == bm[7]) && (r.res[7] != a[7]);
    r.zero  = (r.res == 8'h00);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pop, stall stability and ready rule.
  logic hold_prev = 1'b0;
  res_t prev_out, cur_out, exp_out;
  always @(negedge clk) begin
    cur_out = {out_res, out_carry, out_ovf, out_zero};
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
      if (hold_prev) check("hold_stable", {20'd0, out_valid, cur_out}, {20'd0, 1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_out = exp_q.pop_front();
          check("result", {21'd0, cur_out}, {21'd0, exp_out});
          pop_cyc.push_back(cyc);
        end
      end
      hold_prev = out_valid & ~out_ready;
      prev_out  = cur_out;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic op, input logic [7:0] a, input logic [7:0] b, input res_t e);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int i);
    send(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].res, tbl[i].carry, tbl[i].ovf, tbl[i].zero});
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n, mark, acc, cycs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b1;

    tbl[0] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h01, 8'h80, 8'h81, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};

    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_res", {24'd0, out_res}, 32'd0);
    check("reset_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: latency counted from the accepting cycle.
    send_vec(0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT);
    @(posedge clk);
    #1;
    drain();

    // Whole table back-to-back: one result per cycle, in order.
    mark = pop_cyc.size();
    for (int i = 0; i < NV; i++) send_vec(i);
    drain();
    check("b2b_count", pop_cyc.size() - mark, NV);
    if (pop_cyc.size() - mark == NV)
      check("b2b_consecutive", pop_cyc[pop_cyc.size()-1] - pop_cyc[mark], NV - 1);

    // Consumer stall of 10 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send_vec(i);
        in_valid = 1'b0;
      end
      begin
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with beats in flight and one waiting at the output.
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) send_vec(i);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_res", {24'd0, out_res}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_output", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic against the arithmetic model.
    acc  = 0;
    cycs = 0;
    while (acc < 10000 && cycs < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_op     = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_a, in_b));
        acc++;
      end
      @(posedge clk);
      #1;
      cycs++;
    end
    check("random_accepted", acc, 10000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
